// File: rtl/uart_tx_frame.sv
// uart_tx_frame: parametrised UART transmitter.
// Accepts one character per valid/ready handshake and shifts it out LSB-first
// as start bit, data bits, optional parity bit and one or two stop bits.
// The baud period is latched at accept time, so the source may change
// tx_data/baud_div freely while a frame is on the wire.
module uart_tx_frame #(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int DIV_W     = 16
) (
    input  logic                 fpga_clk,
    input  logic                 rst,
    input  logic [DIV_W-1:0]     baud_div,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 busy_tx,
    output logic                 sout,
    output logic                 tx_done
);

    // Reject illegal configurations at elaboration time.
    generate
        if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
            $error("uart_tx_frame: PARITY must be 0 (none), 1 (even) or 2 (odd)");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
            $error("uart_tx_frame: DATA_BITS must be in 5..9");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
            $error("uart_tx_frame: STOP_BITS must be 1 or 2");
        end
    endgenerate

    localparam int   BCNT_W  = $clog2(DATA_BITS);
    localparam logic PAR_ODD = (PARITY == 2);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_PAR   = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;

    // Control state
    logic [2:0]        r_state;
    logic [DIV_W-1:0]  r_tick;
    logic [BCNT_W-1:0] r_bit;
    logic              r_stop;
    logic              r_sout;
    logic              r_ready;
    logic              r_done;

    // Latched character context
    logic [DIV_W-1:0]     r_div;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par;

    logic w_accept;
    logic w_bit_end;
    logic w_last_data;
    logic w_last_stop;
    logic w_par_calc;

    // r_ready is only high in IDLE, so this alone qualifies an accept.
    assign w_accept    = tx_valid & r_ready;
    // Tick counts 0..r_div inclusive; comparing (not wrapping) keeps an
    // all-ones divisor at a full 2^DIV_W period.
    assign w_bit_end   = (r_tick == r_div);
    assign w_last_data = (r_bit == BCNT_W'(DATA_BITS - 1));
    assign w_last_stop = (r_stop == 1'(STOP_BITS - 1));
    assign w_par_calc  = (^tx_data) ^ PAR_ODD;

    assign tx_ready = r_ready;
    assign busy_tx  = ~r_ready;
    assign sout     = r_sout;
    assign tx_done  = r_done;

    // Frame sequencer: bit timing, state transitions and registered outputs.
    always_ff @(posedge fpga_clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_tick  <= '0;
            r_bit   <= '0;
            r_stop  <= 1'b0;
            r_sout  <= 1'b1;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == S_IDLE) begin
                if (w_accept) begin
                    r_state <= S_START;
                    r_sout  <= 1'b0;
                    r_ready <= 1'b0;
                    r_tick  <= '0;
                end
            end else if (!w_bit_end) begin
                r_tick <= r_tick + 1'b1;
            end else begin
                r_tick <= '0;
                case (r_state)
                    S_START: begin
                        r_state <= S_DATA;
                        r_bit   <= '0;
                        r_sout  <= r_shift[0];
                    end
                    S_DATA: begin
                        if (w_last_data) begin
                            if (PARITY != 0) begin
                                r_state <= S_PAR;
                                r_sout  <= r_par;
                            end else begin
                                r_state <= S_STOP;
                                r_sout  <= 1'b1;
                                r_stop  <= 1'b0;
                            end
                        end else begin
                            r_bit  <= r_bit + 1'b1;
                            // Shift register moves on this same edge, so the
                            // next bit is currently at index 1.
                            r_sout <= r_shift[1];
                        end
                    end
                    S_PAR: begin
                        r_state <= S_STOP;
                        r_sout  <= 1'b1;
                        r_stop  <= 1'b0;
                    end
                    S_STOP: begin
                        if (w_last_stop) begin
                            r_state <= S_IDLE;
                            r_sout  <= 1'b1;
                            r_ready <= 1'b1;
                            r_done  <= 1'b1;
                        end else begin
                            r_stop <= r_stop + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_sout  <= 1'b1;
                        r_ready <= 1'b1;
                    end
                endcase
            end
        end
    end

    // Character context: captured on accept, data shifted at each data-bit boundary.
    always_ff @(posedge fpga_clk) begin
        if (r_state == S_IDLE && w_accept) begin
            r_shift <= tx_data;
            r_div   <= baud_div;
            r_par   <= w_par_calc;
        end else if (r_state == S_DATA && w_bit_end) begin
            r_shift <= r_shift >> 1;
        end
    end

endmodule
